// File: rtl/latch_bus_arbiter.sv
// Round-robin sequencer for a bank of transparent tri-state latches sharing one 8-bit bus.
// Optional macro LATCH_BUS_ARBITER_TURNAROUND_EN adds a one-cycle all-high-Z TURN state.
module latch_bus_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DRIVE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] HOLD_N,
  output logic [NREQ-1:0] OENB_N,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] ACK,
  output logic            BUSY
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {StIdle, StLatch, StDrive, StTurn} state_e;

  state_e          r_state, w_state_d;
  logic [PW-1:0]   r_ptr, w_ptr_d;
  logic [PW-1:0]   r_idx, w_idx_d;
  logic [PW-1:0]   w_win;
  logic [PW:0]     w_sum;
  logic            w_found;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [NREQ-1:0] w_onehot;
  logic [NREQ-1:0] r_hold_n, w_hold_n_d;
  logic [NREQ-1:0] r_oenb_n, w_oenb_n_d;
  logic [NREQ-1:0] r_gnt, w_gnt_d;
  logic [NREQ-1:0] r_ack, w_ack_d;
  logic            r_busy, w_busy_d;

  // First requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      if (!w_found && REQ[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_hold_n <= '0;
      r_oenb_n <= '1;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_ptr    <= w_ptr_d;
      r_idx    <= w_idx_d;
      r_cnt    <= w_cnt_d;
      r_hold_n <= w_hold_n_d;
      r_oenb_n <= w_oenb_n_d;
      r_gnt    <= w_gnt_d;
      r_ack    <= w_ack_d;
      r_busy   <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StLatch;
          w_idx_d   = w_win;
        end
      end
      StLatch: begin
        w_state_d = StDrive;
        w_cnt_d   = CW'(DRIVE_CYCLES - 1);
      end
      StDrive: begin
        if (r_cnt == '0) begin
          w_ptr_d = (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
`ifdef LATCH_BUS_ARBITER_TURNAROUND_EN
          w_state_d = StTurn;
`else
          w_state_d = StIdle;
`endif
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StTurn:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_idx_d;
    w_gnt_d    = (w_state_d != StIdle) ? w_onehot : '0;
    w_hold_n_d = (w_state_d == StLatch) ? w_onehot : '0;
    w_oenb_n_d = (w_state_d == StDrive) ? ~w_onehot : '1;
    w_ack_d    = (w_state_d == StDrive && w_cnt_d == '0) ? w_onehot : '0;
    w_busy_d   = (w_state_d != StIdle);
  end

  assign HOLD_N = r_hold_n;
  assign OENB_N = r_oenb_n;
  assign GNT    = r_gnt;
  assign ACK    = r_ack;
  assign BUSY   = r_busy;

endmodule
